sram_arbiter: RTL and testbench

- Shares one like-SRAM memory port between the instruction-fetch requester and the data-access requester of the five-stage MIPS pipeline.
- Sits between the CPU top (IF-stage and EXE/MEM-stage ports) and the single memory/bridge port.
- Accepts one request at a time into an internal buffer, replays it on the memory port, and routes the response back to its owner.
- Only one transaction is outstanding at any time.

---
 rtl/sram_arbiter_pkg.sv | 13 +
 rtl/arb_grant.sv | 25 ++
 rtl/sram_arbiter.sv | 121 ++++++++++++
 tb/tb_sram_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the SRAM-like port arbiter (state and owner identifiers).
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/arb_grant.sv
// Two-input grant selector: fixed data-over-inst priority, or round-robin
// against the last served requester when SRAM_ARB_RR_EN is defined.
module arb_grant
    import sram_arbiter_pkg::*;
(
    input  logic inst_req,
    input  logic data_req,
    input  logic last_owner,
    output logic grant,
    output logic grant_owner
);

    assign grant = inst_req | data_req;

`ifdef SRAM_ARB_RR_EN
    // On a tie, favour whichever requester was not served last.
    assign grant_owner = (inst_req & data_req) ? ~last_owner
                                               : (data_req ? OWN_DATA : OWN_INST);
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
    assign grant_owner = data_req ? OWN_DATA : OWN_INST;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM-like memory port between the IF and MEM requesters, one
// transaction at a time. Optional round-robin tie-break via SRAM_ARB_RR_EN.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inst_req,
    input  logic [ADDR_WIDTH-1:0]   inst_addr,
    output logic                    inst_addr_ok,
    output logic                    inst_data_ok,
    output logic [DATA_WIDTH-1:0]   inst_rdata,
    input  logic                    data_req,
    input  logic                    data_wr,
    input  logic [DATA_WIDTH/8-1:0] data_wstrb,
    input  logic [ADDR_WIDTH-1:0]   data_addr,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    output logic                    data_addr_ok,
    output logic                    data_data_ok,
    output logic [DATA_WIDTH-1:0]   data_rdata,
    output logic                    mem_req,
    output logic                    mem_wr,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_addr_ok,
    input  logic                    mem_data_ok,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    arb_state_t              state;
    logic                    owner;
    logic                    buf_wr;
    logic [DATA_WIDTH/8-1:0] buf_wstrb;
    logic [ADDR_WIDTH-1:0]   buf_addr;
    logic [DATA_WIDTH-1:0]   buf_wdata;
    logic                    last_owner;
    logic                    grant;
    logic                    grant_owner;
    logic                    accept;
    logic                    done;

    arb_grant u_grant (
        .inst_req    (inst_req),
        .data_req    (data_req),
        .last_owner  (last_owner),
        .grant       (grant),
        .grant_owner (grant_owner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            owner     <= OWN_INST;
            buf_wr    <= 1'b0;
            buf_wstrb <= '0;
            buf_addr  <= '0;
            buf_wdata <= '0;
`ifdef SRAM_ARB_RR_EN
            last_owner <= OWN_DATA;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant) begin
                        owner <= grant_owner;
                        state <= ARB_ADDR;
`ifdef SRAM_ARB_RR_EN
                        last_owner <= grant_owner;
`endif
                        if (grant_owner == OWN_DATA) begin
                            buf_wr    <= data_wr;
                            buf_wstrb <= data_wstrb;
                            buf_addr  <= data_addr;
                            buf_wdata <= data_wdata;
                        end else begin
                            buf_wr    <= 1'b0;
                            buf_wstrb <= '0;
                            buf_addr  <= inst_addr;
                            buf_wdata <= '0;
                        end
                    end
                end
                ARB_ADDR: begin
                    // A same-cycle response completes the transaction outright.
                    if (mem_addr_ok) state <= mem_data_ok ? ARB_IDLE : ARB_DATA;
                end
                ARB_DATA: begin
                    if (mem_data_ok) state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifndef SRAM_ARB_RR_EN
    assign last_owner = OWN_DATA;
`endif

    // Handshakes are suppressed during reset so a dropped transaction never answers.
    assign accept = !reset && (state == ARB_IDLE) && grant;
    assign done   = !reset && mem_data_ok &&
                    ((state == ARB_DATA) || ((state == ARB_ADDR) && mem_addr_ok));

    assign inst_addr_ok = accept && (grant_owner == OWN_INST);
    assign data_addr_ok = accept && (grant_owner == OWN_DATA);
    assign inst_data_ok = done && (owner == OWN_INST);
    assign data_data_ok = done && (owner == OWN_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign mem_req   = (state == ARB_ADDR);
    assign mem_wr    = buf_wr;
    assign mem_wstrb = buf_wstrb;
    assign mem_addr  = buf_addr;
    assign mem_wdata = buf_wdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: requester drivers, a memory responder with
// its own storage, and a transaction-level monitor predicting grants and data.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok = 1'b0;
    logic        mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = '0;

    sram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct packed {
        logic        own;
        logic        rd;
        logic [31:0] rdata;
    } rsp_t;

    logic [31:0] iq[$];
    mreq_t       dq[$];
    mreq_t       exp_mem[$];
    rsp_t        exp_rsp[$];
    logic [31:0] model_mem[logic [31:0]];
    logic [31:0] sram[logic [31:0]];

    int tests = 0;
    int fails = 0;

    int cfg_ad = 0, cfg_dd = 0, exp_lat = 0, stale_req = 0;
    bit cfg_comb = 0, cfg_rand = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C08_BFAF;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) if (strb[b]) res[8*b +: 8] = nw[8*b +: 8];
        return res;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    // Instruction requester
    initial begin
        int n;
        forever begin
            @(posedge clk); #1;
            if (iq.size() != 0) begin
                inst_addr = iq.pop_front();
                inst_req  = 1'b1;
                n = 0;
                @(negedge clk);
                while (!inst_addr_ok && n < 500) begin @(negedge clk); n++; end
                @(posedge clk); #1;
                inst_req  = 1'b0;
                inst_addr = $urandom;
            end
        end
    end

    // Data requester
    initial begin
        int n;
        mreq_t c;
        forever begin
            @(posedge clk); #1;
            if (dq.size() != 0) begin
                c = dq.pop_front();
                data_wr = c.wr; data_wstrb = c.strb; data_addr = c.addr; data_wdata = c.wdata;
                data_req = 1'b1;
                n = 0;
                @(negedge clk);
                while (!data_addr_ok && n < 500) begin @(negedge clk); n++; end
                @(posedge clk); #1;
                data_req   = 1'b0;
                data_wr    = 1'($urandom);
                data_wstrb = 4'($urandom);
                data_addr  = $urandom;
                data_wdata = $urandom;
            end
        end
    end

    // Memory responder with its own storage
    initial begin
        int rph, acnt, dcnt, stale_done;
        bit comb;
        mreq_t cm;
        logic [31:0] old;
        rph = 0; acnt = 0; dcnt = 0; stale_done = 0; comb = 0;
        forever begin
            @(posedge clk); #2;
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b0;
            if (stale_done != stale_req) begin
                stale_done++;
                mem_data_ok = 1'b1;
                mem_rdata   = 32'hDEAD_BEEF;
                rph = 0;
            end else if (reset) begin
                rph = 0;
            end else begin
                if (rph == 0 && mem_req) begin
                    cm = '{mem_wr, mem_wstrb, mem_addr, mem_wdata};
                    if (cfg_rand) begin
                        acnt = $urandom_range(3, 0);
                        dcnt = $urandom_range(3, 0);
                        comb = ($urandom_range(3, 0) == 0);
                    end else begin
                        acnt = cfg_ad; dcnt = cfg_dd; comb = cfg_comb;
                    end
                    rph = 1;
                end
                if (rph == 1) begin
                    if (acnt > 0) acnt--;
                    else begin
                        mem_addr_ok = 1'b1;
                        rph = comb ? 3 : 2;
                    end
                end else if (rph == 2) begin
                    if (dcnt > 0) dcnt--;
                    else rph = 3;
                end
                if (rph == 3) begin
                    mem_data_ok = 1'b1;
                    old = sram.exists(cm.addr) ? sram[cm.addr] : init_word(cm.addr);
                    if (cm.wr) begin
                        sram[cm.addr] = merge(old, cm.wdata, cm.strb);
                        mem_rdata = $urandom;
                    end else begin
                        mem_rdata = old;
                    end
                    rph = 0;
                end
            end
        end
    end

    // Monitor / scoreboard
    bit   busy = 0, addr_done = 0, post_rst = 0;
    logic last_srv = OWN_DATA;
    int   cyc = 0, acc_cyc = 0, busy_cnt = 0;

    initial begin
        bit    hs, due;
        logic  own;
        mreq_t m;
        rsp_t  r;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                chk("reset_quiet", {60'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 64'd0);
                exp_mem.delete(); exp_rsp.delete();
                busy = 0; addr_done = 0; busy_cnt = 0; last_srv = OWN_DATA; post_rst = 1;
            end else begin
                if (post_rst) begin
                    post_rst = 0;
                    chk("reset_mem_ctl", {58'd0, mem_req, mem_wr, mem_wstrb}, 64'd0);
                    chk("reset_mem_addr", {32'd0, mem_addr}, 64'd0);
                    chk("reset_mem_wdata", {32'd0, mem_wdata}, 64'd0);
                    chk("reset_data_ok", {62'd0, inst_data_ok, data_data_ok}, 64'd0);
                end
                hs  = mem_req && mem_addr_ok;
                due = mem_data_ok && (addr_done || hs);

                if (!busy && (inst_req || data_req)) begin
                    if (inst_req && data_req) begin
`ifdef SRAM_ARB_RR_EN
                        own = ~last_srv;
`else
                        own = OWN_DATA;
`endif
                    end else begin
                        own = data_req ? OWN_DATA : OWN_INST;
                    end
                    chk("grant", {62'd0, data_addr_ok, inst_addr_ok}, (own == OWN_DATA) ? 64'd2 : 64'd1);
                    if (own == OWN_DATA) m = '{data_wr, data_wstrb, data_addr, data_wdata};
                    else                 m = '{1'b0, 4'h0, inst_addr, 32'h0};
                    r.own   = own;
                    r.rd    = !m.wr;
                    r.rdata = model_mem.exists(m.addr) ? model_mem[m.addr] : init_word(m.addr);
                    if (m.wr) model_mem[m.addr] = merge(r.rdata, m.wdata, m.strb);
                    exp_mem.push_back(m);
                    exp_rsp.push_back(r);
                    busy = 1; last_srv = own; acc_cyc = cyc;
                end else begin
                    chk("no_addr_ok", {62'd0, data_addr_ok, inst_addr_ok}, 64'd0);
                end

                if (mem_req) begin
                    if (exp_mem.size() == 0) chk("mem_req_unexpected", 64'd1, 64'd0);
                    else begin
                        m = exp_mem[0];
                        chk("mem_addr", {32'd0, mem_addr}, {32'd0, m.addr});
                        chk("mem_ctl", {59'd0, mem_wr, mem_wstrb}, {59'd0, m.wr, m.strb});
                        if (m.wr) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, m.wdata});
                        if (hs) void'(exp_mem.pop_front());
                    end
                end

                if (due) begin
                    if (exp_rsp.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
                    else begin
                        r = exp_rsp.pop_front();
                        chk("data_ok_route", {62'd0, inst_data_ok, data_data_ok},
                            (r.own == OWN_DATA) ? 64'd1 : 64'd2);
                        if (r.rd && r.own == OWN_DATA) chk("data_rdata", {32'd0, data_rdata}, {32'd0, r.rdata});
                        if (r.rd && r.own == OWN_INST) chk("inst_rdata", {32'd0, inst_rdata}, {32'd0, r.rdata});
                        if (exp_lat != 0) chk("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
                    end
                    busy = 0; addr_done = 0; busy_cnt = 0;
                end else begin
                    if (hs) addr_done = 1;
                    if (mem_data_ok || inst_data_ok || data_data_ok)
                        chk("no_data_ok", {62'd0, inst_data_ok, data_data_ok}, 64'd0);
                end

                if (busy) begin
                    busy_cnt++;
                    if (busy_cnt > 300) begin
                        chk("hang", 64'd1, 64'd0);
                        exp_mem.delete(); exp_rsp.delete();
                        busy = 0; addr_done = 0; busy_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((iq.size() != 0 || dq.size() != 0 || inst_req || data_req || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 64'd1, 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Stimulus
    initial begin
        mreq_t c;
        int n;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single instruction read, best-case memory
        exp_lat = 2;
        iq.push_back(32'hBFC0_0000);
        drain();
        exp_lat = 0;

        // Partial-strobe data write, then read back the merged word
        dq.push_back('{1'b1, 4'b0011, 32'h8000_1000, 32'h1234_ABCD});
        drain();
        dq.push_back('{1'b0, 4'b0000, 32'h8000_1000, 32'h0});
        drain();

        // Simultaneous requests in IDLE
        @(negedge clk);
        iq.push_back(32'h8000_0004);
        dq.push_back('{1'b0, 4'b0000, 32'h8000_0008, 32'h0});
        drain();

        // Stalled memory address phase with a competing request pending
        cfg_ad = 5;
        @(negedge clk);
        dq.push_back('{1'b1, 4'b1111, 32'h8000_000C, 32'hCAFE_F00D});
        iq.push_back(32'h8000_000C);
        drain();
        cfg_ad = 0;

        // Combined address/data handshake, back-to-back requests
        cfg_comb = 1;
        exp_lat  = 1;
        @(negedge clk);
        dq.push_back('{1'b0, 4'b0000, 32'h8000_0010, 32'h0});
        iq.push_back(32'h8000_0014);
        drain();
        exp_lat  = 0;
        cfg_comb = 0;

        // Reset while waiting for data, then a stale response
        cfg_dd = 10;
        @(negedge clk);
        dq.push_back('{1'b0, 4'b0000, 32'h8000_0018, 32'h0});
        n = 0;
        @(negedge clk);
        while (!(mem_req && mem_addr_ok) && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("reach_data_state", 64'd0, 64'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        stale_req++;
        repeat (4) @(negedge clk);
        cfg_dd = 0;

        // Randomised mixed traffic
        cfg_rand = 1;
        @(negedge clk);
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                iq.push_back(32'h8000_0000 + 32'($urandom_range(7, 0)) * 4);
            end else begin
                c.wr    = 1'($urandom_range(1, 0));
                c.strb  = 4'($urandom);
                c.addr  = 32'h8000_0000 + 32'($urandom_range(7, 0)) * 4;
                c.wdata = $urandom;
                dq.push_back(c);
            end
        end
        drain();
        cfg_rand = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
